// File: rtl/cpack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpack_pkg
// Description : Shared definitions for the cpack compressor / decompressor
//               pair: pattern encodings, dictionary geometry and the rule
//               that decides whether a code refreshes the dictionary.
// Revision    : 1.0 - initial release
// ============================================================================
package cpack_pkg;

    localparam int WORD_W     = 32;
    localparam int DICT_WORDS = 16;
    localparam int IDX_W      = 4;

    // Pattern codes; 6 and 7 are illegal and never produced by the encoder.
    typedef enum logic [2:0] {
        PAT_ZZZZ = 3'd0,
        PAT_ZZZX = 3'd1,
        PAT_MMMM = 3'd2,
        PAT_MMXX = 3'd3,
        PAT_MMMX = 3'd4,
        PAT_XXXX = 3'd5
    } pattern_e;

    // Only codes that carry new literal bytes push the word into the
    // dictionary; full matches and zero words would just duplicate entries.
    function automatic logic writes_dict(input logic [2:0] pat);
        return (pat == PAT_MMXX) || (pat == PAT_MMMX) || (pat == PAT_XXXX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpack_dict_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cpack_dict_fifo
// Description : FIFO-replacement dictionary. WORDS x WIDTH register array with
//               a wrapping write pointer, synchronous clear, combinational
//               read port and a packed view of all entries.
// Ports       : clk/rst_n  - clock, asynchronous active-low reset
//               clear      - zero all entries and the pointer (wins over write)
//               wr_en/wr_data - write at the pointer, then advance it
//               rd_idx/rd_data - combinational read (pre-update contents)
//               dict_flat  - entry k at bits [k*WIDTH +: WIDTH]
// Revision    : 1.0 - initial release
// ============================================================================
module cpack_dict_fifo #(
    parameter int WIDTH = 32,
    parameter int WORDS = 16,
    parameter int IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [WIDTH-1:0]       rd_data,
    output logic [WORDS*WIDTH-1:0] dict_flat
);

    logic [WIDTH-1:0] entries [WORDS];
    logic [IDX_W-1:0] wr_ptr;

    // WORDS is a power of two, so the pointer wraps 15 -> 0 on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < WORDS; k++) begin
                entries[k] <= '0;
            end
            wr_ptr <= '0;
        end else if (clear) begin
            for (int k = 0; k < WORDS; k++) begin
                entries[k] <= '0;
            end
            wr_ptr <= '0;
        end else if (wr_en) begin
            entries[wr_ptr] <= wr_data;
            wr_ptr          <= wr_ptr + 1'b1;
        end
    end

    assign rd_data = entries[rd_idx];

    generate
        for (genvar k = 0; k < WORDS; k++) begin : g_pack
            assign dict_flat[k*WIDTH +: WIDTH] = entries[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/cpack_word_decoder.sv
`default_nettype none
// ============================================================================
// Module      : cpack_word_decoder
// Description : Rebuilds 32-bit words from pre-parsed cpack codes and keeps a
//               dictionary in lock-step with the compressor's.
// Ports       : clk_i/rst_ni            - clock, async active-low reset
//               clear_i                 - block-boundary dictionary clear
//               in_valid_i/in_ready_o   - code handshake
//               pattern_i/index_i/literal_i - code fields
//               out_valid_o/out_ready_i/word_o - decoded word handshake
//               dictionary_o            - packed dictionary contents
//               err_o                   - sticky illegal-pattern flag
//               word_cnt_o              - words delivered downstream
// Revision    : 1.0 - initial release
// ============================================================================
module cpack_word_decoder #(
    parameter int WIDTH = 32,
    parameter int WORDS = 16,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [2:0]             pattern_i,
    input  logic [IDX_W-1:0]       index_i,
    input  logic [WIDTH-1:0]       literal_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [WIDTH-1:0]       word_o,
    output logic [WORDS*WIDTH-1:0] dictionary_o,
    output logic                   err_o,
    output logic [CNT_W-1:0]       word_cnt_o
);

    import cpack_pkg::*;

    logic             accept;
    logic             dict_wr;
    logic             illegal;
    logic [WIDTH-1:0] dict_word;
    logic [WIDTH-1:0] dec_word;

    // The output slot frees up in the same cycle it is drained.
    assign in_ready_o = !out_valid_o || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign dict_wr    = accept && writes_dict(pattern_i);

    cpack_dict_fifo #(
        .WIDTH (WIDTH),
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_dict (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .clear     (clear_i),
        .wr_en     (dict_wr),
        .wr_data   (dec_word),
        .rd_idx    (index_i),
        .rd_data   (dict_word),
        .dict_flat (dictionary_o)
    );

    // Decode against the current (pre-update) dictionary contents.
    always_comb begin
        dec_word = '0;
        illegal  = 1'b0;
        case (pattern_i)
            PAT_ZZZZ: dec_word = '0;
            PAT_ZZZX: dec_word = {{(WIDTH-8){1'b0}}, literal_i[7:0]};
            PAT_MMMM: dec_word = dict_word;
            PAT_MMXX: dec_word = {dict_word[WIDTH-1:16], literal_i[15:0]};
            PAT_MMMX: dec_word = {dict_word[WIDTH-1:8], literal_i[7:0]};
            PAT_XXXX: dec_word = literal_i;
            default:  illegal  = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            word_o      <= '0;
            err_o       <= 1'b0;
            word_cnt_o  <= '0;
        end else begin
            if (out_valid_o && out_ready_i) begin
                word_cnt_o <= word_cnt_o + 1'b1;
            end
            if (accept) begin
                out_valid_o <= 1'b1;
                word_o      <= dec_word;
                if (illegal) begin
                    err_o <= 1'b1;
                end
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpack_word_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpack_word_decoder
// Description : Self-checking bench for cpack_word_decoder: directed vector
//               table, hand-written stall/clear/reset sequences and random
//               traffic against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpack_word_decoder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   pattern;
    logic [3:0]   idx;
    logic [31:0]  lit;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  word;
    logic [511:0] dict;
    logic         err;
    logic [15:0]  cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_dict [16];
    int          m_wr;
    logic        m_valid;
    logic [31:0] m_word;
    logic        m_err;
    int          m_cnt;

    always #5 clk = ~clk;

    cpack_word_decoder dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .pattern_i    (pattern),
        .index_i      (idx),
        .literal_i    (lit),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .word_o       (word),
        .dictionary_o (dict),
        .err_o        (err),
        .word_cnt_o   (cnt)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] model_flat();
        logic [511:0] f;
        for (int k = 0; k < 16; k++) f[k*32 +: 32] = m_dict[k];
        return f;
    endfunction

    function automatic logic [31:0] ref_word(input logic [2:0] p, input logic [3:0] i,
                                             input logic [31:0] l);
        case (p)
            3'd0:    return 32'h0;
            3'd1:    return l & 32'h0000_00FF;
            3'd2:    return m_dict[i];
            3'd3:    return (m_dict[i] & 32'hFFFF_0000) | (l & 32'h0000_FFFF);
            3'd4:    return (m_dict[i] & 32'hFFFF_FF00) | (l & 32'h0000_00FF);
            3'd5:    return l;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 16; k++) m_dict[k] = 32'h0;
        m_wr = 0; m_valid = 1'b0; m_word = 32'h0; m_err = 1'b0; m_cnt = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        logic        acc;
        logic [31:0] w;
        acc = in_valid && (!m_valid || out_ready);
        if (m_valid && out_ready) m_cnt++;
        if (acc) begin
            w = ref_word(pattern, idx, lit);
            if (pattern > 3'd5) m_err = 1'b1;
            if (!clear && (pattern inside {3'd3, 3'd4, 3'd5})) begin
                m_dict[m_wr % 16] = w;
                m_wr++;
            end
            m_valid = 1'b1;
            m_word  = w;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (clear) begin
            for (int k = 0; k < 16; k++) m_dict[k] = 32'h0;
            m_wr = 0;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".out_valid"}, 512'(out_valid), 512'(m_valid));
        chk({tag, ".word"},      512'(word),      512'(m_word));
        chk({tag, ".err"},       512'(err),       512'(m_err));
        chk({tag, ".cnt"},       512'(cnt),       512'(m_cnt[15:0]));
        chk({tag, ".dict"},      dict,            model_flat());
    endtask

    // One clock with the inputs as currently driven; checks before and after.
    task automatic cycle(input string tag);
        #1;
        chk({tag, ".in_ready"}, 512'(in_ready), 512'(!m_valid || out_ready));
        model_step();
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic send(input logic [2:0] p, input logic [3:0] i, input logic [31:0] l);
        in_valid = 1'b1; pattern = p; idx = i; lit = l;
        cycle("send");
    endtask

    task automatic idle();
        in_valid = 1'b0;
        cycle("idle");
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pattern = 3'd0; idx = 4'd0; lit = 32'h0;
        #3;
        model_reset();
        check_state("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  pat;
        logic [3:0]  idx;
        logic [31:0] lit;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{3'd5, 4'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF}; // XXXX -> entry0
        vecs[1] = '{3'd2, 4'd0, 32'h0,         32'hDEAD_BEEF}; // MMMM idx0
        vecs[2] = '{3'd3, 4'd0, 32'h0000_1234, 32'hDEAD_1234}; // MMXX -> entry1
        vecs[3] = '{3'd4, 4'd1, 32'h0000_0056, 32'hDEAD_1256}; // MMMX sees entry1
        vecs[4] = '{3'd0, 4'd3, 32'hFFFF_FFFF, 32'h0000_0000}; // ZZZZ
        vecs[5] = '{3'd1, 4'd0, 32'hFFFF_FFA5, 32'h0000_00A5}; // ZZZX
        vecs[6] = '{3'd6, 4'd0, 32'h1234_5678, 32'h0000_0000}; // illegal

        // --- directed table ---
        do_reset();
        for (int v = 0; v < 7; v++) begin
            send(vecs[v].pat, vecs[v].idx, vecs[v].lit);
            chk($sformatf("vec%0d.word", v), 512'(word), 512'(vecs[v].exp));
        end
        idle();
        chk("tbl.entry0", 512'(dict[31:0]),  512'(32'hDEAD_BEEF));
        chk("tbl.entry1", 512'(dict[63:32]), 512'(32'hDEAD_1234));
        chk("tbl.entry2", 512'(dict[95:64]), 512'(32'hDEAD_1256));
        chk("tbl.entry3", 512'(dict[127:96]), 512'(32'h0));
        chk("tbl.err",    512'(err),         512'(1'b1));
        chk("tbl.cnt",    512'(cnt),         512'(16'd7));

        // --- dictionary wrap: 17 literal words ---
        do_reset();
        for (int n = 1; n <= 17; n++) send(3'd5, 4'd0, 32'(n));
        chk("wrap.entry0", 512'(dict[31:0]), 512'(32'd17));
        for (int k = 1; k < 16; k++)
            chk($sformatf("wrap.entry%0d", k), 512'(dict[k*32 +: 32]), 512'(32'(k + 1)));
        send(3'd5, 4'd0, 32'h99);
        chk("wrap.ptr1", 512'(dict[63:32]), 512'(32'h99));

        // --- backpressure ---
        do_reset();
        send(3'd5, 4'd0, 32'hA);
        out_ready = 1'b0;
        pattern = 3'd5; lit = 32'hB;
        for (int s = 0; s < 3; s++) begin
            cycle("stall");
            chk("stall.in_ready", 512'(in_ready), 512'(1'b0));
            chk("stall.word",     512'(word),     512'(32'hA));
        end
        out_ready = 1'b1;
        cycle("release");
        chk("release.word", 512'(word), 512'(32'hB));
        send(3'd5, 4'd0, 32'hC);
        chk("next.word", 512'(word), 512'(32'hC));
        idle();
        chk("bp.cnt", 512'(cnt), 512'(16'd3));

        // --- illegal pattern and clear ---
        do_reset();
        send(3'd5, 4'd0, 32'hAAAA_AAAA);
        send(3'd7, 4'd0, 32'h0);
        chk("ill.err", 512'(err), 512'(1'b1));
        clear = 1'b1;
        send(3'd5, 4'd0, 32'h1111_1111);
        clear = 1'b0;
        chk("clr.word", 512'(word), 512'(32'h1111_1111));
        chk("clr.dict", dict,       512'(0));
        chk("clr.err",  512'(err),  512'(1'b1));
        send(3'd2, 4'd0, 32'h0);
        chk("clr.mmmm", 512'(word), 512'(32'h0));
        send(3'd5, 4'd0, 32'h77);
        clear = 1'b1;
        send(3'd2, 4'd0, 32'h0);
        clear = 1'b0;
        chk("clr.preclear", 512'(word), 512'(32'h77));
        chk("clr.dict2",    dict,       512'(0));

        // --- reset while a word is pending ---
        out_ready = 1'b0;
        send(3'd5, 4'd0, 32'h5555_5555);
        #2 rst_n = 1'b0;
        #1;
        chk("rst.out_valid", 512'(out_valid), 512'(1'b0));
        chk("rst.word",      512'(word),      512'(32'h0));
        chk("rst.cnt",       512'(cnt),       512'(16'd0));
        do_reset();
        send(3'd2, 4'd0, 32'h0);
        chk("rst.mmmm", 512'(word), 512'(32'h0));

        // --- random traffic against the model ---
        do_reset();
        for (int r = 0; r < 600; r++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 39) == 0);
            pattern   = ($urandom_range(0, 49) == 0) ? 3'(6 + $urandom_range(0, 1))
                                                     : 3'($urandom_range(0, 5));
            idx       = 4'($urandom_range(0, 15));
            lit       = $urandom;
            cycle("rand");
        end
        clear = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
